// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: PC/instruction memory, hazard and redirect inputs, IF/ID outputs.
// Signal prefixes are from the fetch stage's point of view (slave modport).
interface fetch_if;
    logic [31:0] o_pc;
    logic [31:0] i_instr_code;
    logic        i_stall;
    logic        i_branch_taken;
    logic [31:0] i_branch_target;
    logic        i_jump;
    logic [31:0] o_ifid_instr;
    logic [31:0] o_ifid_pc4;
    logic        o_ifid_valid;
    logic        o_fetch_fault;
    logic [31:0] o_fetch_count;

    modport slave (
        input  i_instr_code, i_stall, i_branch_taken, i_branch_target, i_jump,
        output o_pc, o_ifid_instr, o_ifid_pc4, o_ifid_valid, o_fetch_fault, o_fetch_count
    );

    modport master (
        output i_instr_code, i_stall, i_branch_taken, i_branch_target, i_jump,
        input  o_pc, o_ifid_instr, o_ifid_pc4, o_ifid_valid, o_fetch_fault, o_fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID register and bad-address trap.
// state | meaning:  RUN = normal fetching,  FAULT = bad address seen, wait for a redirect
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 128
) (
    input  logic   i_clk,
    input  logic   i_rst,
    fetch_if.slave bus
);
    localparam logic [0:0]  ST_RUN    = 1'b0;
    localparam logic [0:0]  ST_FAULT  = 1'b1;
    localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - 4);

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;
    logic        r_fetch_fault;
    logic [31:0] r_fetch_count;

    logic        w_bad_addr;
    logic        w_jump_act;
    logic        w_redirect;
    logic        w_in_fault;
    logic [31:0] w_pc4;
    logic [31:0] w_jump_target;
    logic [31:0] w_pc_next;

    assign w_bad_addr    = (r_pc[1:0] != 2'b00) || (r_pc > LAST_WORD);
    assign w_jump_act    = bus.i_jump && r_ifid_valid;
    assign w_redirect    = bus.i_branch_taken || w_jump_act;
    assign w_in_fault    = (r_state == ST_FAULT);
    assign w_pc4         = r_pc + 32'd4;
    assign w_jump_target = {r_ifid_pc4[31:28], r_ifid_instr[25:0], 2'b00};

    // A bad address holds the PC on the trapping edge too, so the faulting pc stays visible.
    always_comb begin
        w_pc_next = w_pc4;
        if (bus.i_branch_taken)
            w_pc_next = bus.i_branch_target;
        else if (w_jump_act)
            w_pc_next = w_jump_target;
        else if (bus.i_stall || w_in_fault || w_bad_addr)
            w_pc_next = r_pc;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_pc <= RESET_PC;
        else
            r_pc <= w_pc_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ifid_instr  <= 32'd0;
            r_ifid_pc4    <= 32'd0;
            r_ifid_valid  <= 1'b0;
            r_fetch_count <= 32'd0;
        end else if (w_redirect) begin
            r_ifid_instr  <= 32'd0;
            r_ifid_pc4    <= 32'd0;
            r_ifid_valid  <= 1'b0;
        end else if (bus.i_stall) begin
            r_ifid_instr  <= r_ifid_instr;
        end else if (w_in_fault || w_bad_addr) begin
            r_ifid_instr  <= 32'd0;
            r_ifid_pc4    <= 32'd0;
            r_ifid_valid  <= 1'b0;
        end else begin
            r_ifid_instr  <= bus.i_instr_code;
            r_ifid_pc4    <= w_pc4;
            r_ifid_valid  <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_RUN;
            r_fetch_fault <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_bad_addr && !w_redirect) begin
                        r_state       <= ST_FAULT;
                        r_fetch_fault <= 1'b1;
                    end
                end
                default: begin
                    if (w_redirect)
                        r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.o_pc          = r_pc;
    assign bus.o_ifid_instr  = r_ifid_instr;
    assign bus.o_ifid_pc4    = r_ifid_pc4;
    assign bus.o_ifid_valid  = r_ifid_valid;
    assign bus.o_fetch_fault = r_fetch_fault;
    assign bus.o_fetch_count = r_fetch_count;
endmodule
